// File: rtl/wash_pkg.sv
// Shared state encoding, default phase lengths and the timer load helper
// used by the wash sequencer and its phase timer.
package wash_pkg;

    typedef logic [2:0] wash_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_WASH   = 3'd2;
    localparam logic [2:0] ST_DRAIN1 = 3'd3;
    localparam logic [2:0] ST_RFILL  = 3'd4;
    localparam logic [2:0] ST_RINSE  = 3'd5;
    localparam logic [2:0] ST_DRAIN2 = 3'd6;
    localparam logic [2:0] ST_SPIN   = 3'd7;

    localparam int unsigned WASH_CYCLES_DEF  = 16;
    localparam int unsigned RINSE_CYCLES_DEF = 8;
    localparam int unsigned DRAIN_CYCLES_DEF = 6;
    localparam int unsigned SPIN_CYCLES_DEF  = 12;
    localparam int unsigned FILL_TIMEOUT_DEF = 32;

    // A phase of N clocks loads N-1; 0 and 1 both collapse to a one-clock phase.
    function automatic logic [15:0] phase_load(input int unsigned cycles);
        if (cycles <= 1) begin
            return 16'd0;
        end
        return 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable 16-bit down-counter shared by every timed phase of the sequencer;
// it holds at zero until the next load.
module wash_phase_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_value,
    output logic        o_zero
);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != 16'd0) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_zero = (r_count == 16'd0);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine cycle sequencer: fill, wash, drain, rinse fill, rinse, drain, spin.
// Optional fill-state watchdog and sticky fault output: WASH_SEQUENCER_FILL_TIMEOUT_EN.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned WASH_CYCLES  = WASH_CYCLES_DEF,
    parameter int unsigned RINSE_CYCLES = RINSE_CYCLES_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned SPIN_CYCLES  = SPIN_CYCLES_DEF,
    parameter int unsigned FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       fill_ready,
    output logic       fill_start,
    output logic       motor_on,
    output logic       spin_fast,
    output logic       drain_on,
    output logic       busy,
    output logic       done,
`ifdef WASH_SEQUENCER_FILL_TIMEOUT_EN
    output logic       fault,
`endif
    output logic [2:0] state_o
);

    localparam logic [15:0] LD_WASH  = phase_load(WASH_CYCLES);
    localparam logic [15:0] LD_RINSE = phase_load(RINSE_CYCLES);
    localparam logic [15:0] LD_DRAIN = phase_load(DRAIN_CYCLES);
    localparam logic [15:0] LD_SPIN  = phase_load(SPIN_CYCLES);
    localparam logic [15:0] LD_FILL  = phase_load(FILL_TIMEOUT);

    wash_state_t r_state;
    wash_state_t w_next_state;
    logic        r_done;
    logic        w_load;
    logic [15:0] w_load_val;
    logic        w_timer_zero;
    logic        w_set_done;
    logic        w_clr_done;
`ifdef WASH_SEQUENCER_FILL_TIMEOUT_EN
    logic        r_fault;
    logic        w_set_fault;
`endif

    wash_phase_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_timer_zero)
    );

    // Abort has priority over both fill_ready and timer expiry in every abortable state.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = 16'd0;
        w_set_done   = 1'b0;
        w_clr_done   = 1'b0;
`ifdef WASH_SEQUENCER_FILL_TIMEOUT_EN
        w_set_fault  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_FILL;
                    w_load       = 1'b1;
                    w_load_val   = LD_FILL;
                    w_clr_done   = 1'b1;
                end
            end
            ST_FILL, ST_RFILL: begin
                if (abort) begin
                    w_next_state = ST_DRAIN2;
                    w_load       = 1'b1;
                    w_load_val   = LD_DRAIN;
                end else if (fill_ready) begin
                    w_next_state = (r_state == ST_FILL) ? ST_WASH : ST_RINSE;
                    w_load       = 1'b1;
                    w_load_val   = (r_state == ST_FILL) ? LD_WASH : LD_RINSE;
                end
`ifdef WASH_SEQUENCER_FILL_TIMEOUT_EN
                else if (w_timer_zero) begin
                    w_next_state = ST_DRAIN2;
                    w_load       = 1'b1;
                    w_load_val   = LD_DRAIN;
                    w_set_fault  = 1'b1;
                end
`endif
            end
            ST_WASH, ST_RINSE, ST_DRAIN1: begin
                if (abort) begin
                    w_next_state = ST_DRAIN2;
                    w_load       = 1'b1;
                    w_load_val   = LD_DRAIN;
                end else if (w_timer_zero) begin
                    w_load = 1'b1;
                    if (r_state == ST_WASH) begin
                        w_next_state = ST_DRAIN1;
                        w_load_val   = LD_DRAIN;
                    end else if (r_state == ST_RINSE) begin
                        w_next_state = ST_DRAIN2;
                        w_load_val   = LD_DRAIN;
                    end else begin
                        w_next_state = ST_RFILL;
                        w_load_val   = LD_FILL;
                    end
                end
            end
            ST_DRAIN2: begin
                if (w_timer_zero) begin
                    w_next_state = ST_SPIN;
                    w_load       = 1'b1;
                    w_load_val   = LD_SPIN;
                end
            end
            ST_SPIN: begin
                if (w_timer_zero) begin
                    w_next_state = ST_IDLE;
                    w_set_done   = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_clr_done) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef WASH_SEQUENCER_FILL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else if (w_clr_done) begin
            r_fault <= 1'b0;
        end else if (w_set_fault) begin
            r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;
`endif

    assign fill_start = (r_state == ST_FILL) || (r_state == ST_RFILL);
    assign motor_on   = (r_state == ST_WASH) || (r_state == ST_RINSE) || (r_state == ST_SPIN);
    assign spin_fast  = (r_state == ST_SPIN);
    assign drain_on   = (r_state == ST_DRAIN1) || (r_state == ST_DRAIN2) || (r_state == ST_SPIN);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign state_o    = r_state;

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter WASH_CYCLES, default 16: clocks spent in WASH.
REQ-002 Parameter RINSE_CYCLES, default 8: clocks spent in RINSE.
REQ-003 Parameter DRAIN_CYCLES, default 6: clocks spent in each DRAIN.
REQ-004 Parameter SPIN_CYCLES, default 12: clocks spent in SPIN.
REQ-005 Parameter FILL_TIMEOUT, default 32: maximum clocks in a fill state (used only under REQ-031).
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-008 start  input  1  request to begin a cycle; sampled in IDLE only.
REQ-009 abort  input  1  abandon current cycle, go to drain-out.
REQ-010 fill_ready  input  1  water level reached, from fill block.
REQ-011 fill_start  output  1  fill request to fill block; held high for whole fill state.
REQ-012 motor_on  output  1  drum motor enable.
REQ-013 spin_fast  output  1  high-speed spin select, valid with motor_on.
REQ-014 drain_on  output  1  drain valve open.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  high only in DONE.
REQ-017 state_o  output  3  current state encoding.

Function
REQ-018 States: IDLE=0, FILL=1, WASH=2, DRAIN1=3, RFILL=4, RINSE=5, DRAIN2=6, SPIN=7; DONE is SPIN exit flag plus IDLE-encoding, done register set.
REQ-019 IDLE -> FILL when start=1; done clears on same edge.
REQ-020 FILL, RFILL: fill_start=1; exit to WASH / RINSE on first clock fill_ready=1 is sampled.
REQ-021 WASH, RINSE: motor_on=1, spin_fast=0; 16-bit down-counter loaded with N-1 on entry; exit when counter=0, so state lasts exactly N clocks.
REQ-022 DRAIN1 -> RFILL, DRAIN2 -> SPIN after DRAIN_CYCLES clocks; drain_on=1.
REQ-023 SPIN: motor_on=1, spin_fast=1, drain_on=1; after SPIN_CYCLES -> IDLE with done=1.
REQ-024 done stays 1 in IDLE until next accepted start or reset.
REQ-025 Outputs decoded from registered state only; fill_start low on the edge fill state is left.
REQ-026 abort=1 in FILL, WASH, RFILL, RINSE -> DRAIN2 next clock with counter reloaded; abort in DRAIN1 -> DRAIN2; abort in DRAIN2, SPIN, IDLE ignored.
REQ-027 abort and counter expiry on same edge: abort wins.
REQ-028 start while busy ignored; start and abort together in IDLE: start accepted.
REQ-029 A parameter of 0 or 1 yields a one-clock state.

Reset
REQ-030 reset=0: state=IDLE, counter=0, done=0, all outputs 0, independent of clk; first transition at first rising clk after release.

Configuration
REQ-031 Macro WASH_SEQUENCER_FILL_TIMEOUT_EN defined: fill-state clock counter; FILL_TIMEOUT clocks without fill_ready -> DRAIN2 and sticky output fault (1 bit, cleared by reset or next accepted start). Undefined: no fault port, fill states wait indefinitely, FILL_TIMEOUT unused.

Structure
REQ-032 Shared package wash_pkg holds the state enum/encoding and the default cycle constants.
REQ-033 One sub-module wash_phase_timer: loadable 16-bit down-counter with load, value, and zero flag, reused for all timed states.

Verification
REQ-034 Normal cycle, fill_ready after 9 clocks each fill: state sequence 1,2,3,4,5,6,7,IDLE; WASH 16, RINSE 8, DRAIN 6 each, SPIN 12 clocks; done=1 after.
REQ-035 abort pulse at WASH clock 5: next state DRAIN2, drain_on=1 for 6 clocks, then SPIN 12 clocks, done=1.
REQ-036 reset=0 asserted mid-RINSE between clock edges: all outputs 0 immediately; start after release restarts at FILL.
REQ-037 start pulsed during SPIN: ignored, cycle length unchanged; start in IDLE with done=1: done clears, FILL entered.
REQ-038 Macro defined, fill_ready held 0: at FILL clock 32 state -> DRAIN2, fault=1; macro undefined: FILL held 100 clocks, no exit.
REQ-039 abort and WASH counter=0 same edge: next state DRAIN2, not DRAIN1.
